ysyx_22050518_div_seq: RTL and testbench

- Multi-cycle RV64 integer divide sequencer for the EXU. Covers DIV, DIVU, REM and REMU, 64-bit only.
- Owns no adder of its own. It drives one external 64-bit adder instance (add_* ports) every cycle: two's-complement negation and restoring-division subtract steps.
- Valid/ready handshake on both request and result sides. Flush input for pipeline kill.

---
 rtl/ysyx_22050518_div_seq.sv | 167 ++++++++++++++++
 tb/tb_ysyx_22050518_div_seq.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050518_div_seq.sv
// Multi-cycle RV64 divide sequencer (DIV/DIVU/REM/REMU).
// Drives a shared external adder for negation and restoring-division steps.
module ysyx_22050518_div_seq #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_signed,
    input  logic            req_rem,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic [XLEN-1:0] add_in1,
    output logic [XLEN-1:0] add_in2,
    output logic            add_cin,
    input  logic [XLEN-1:0] add_out,
    input  logic            add_cout
);

    typedef enum logic [2:0] {
        IDLE,
        NEGA,
        NEGB,
        ITER,
        NEGQ,
        NEGR,
        DONE
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state_q;
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [XLEN-1:0]  q_q;
    logic [XLEN-1:0]  r_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rem_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic [XLEN-1:0]  rsp_data_q;

    logic [XLEN-1:0]  shifted;
    logic             ok;
    logic             b_zero;
    logic             ovf;

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_data  = rsp_data_q;

    assign shifted = {r_q[XLEN-2:0], q_q[XLEN-1]};
    // R[63] set means the shifted value is 65 bits wide and always >= B.
    assign ok      = add_cout | r_q[XLEN-1];
    assign b_zero  = (req_b == '0);
    assign ovf     = req_signed & (req_a == MIN_NEG) & (req_b == '1);

    always_comb begin
        add_in1 = '0;
        add_in2 = '0;
        add_cin = 1'b0;
        unique case (state_q)
            NEGA: begin
                add_in1 = ~a_q;
                add_cin = 1'b1;
            end
            NEGB: begin
                add_in1 = ~b_q;
                add_cin = 1'b1;
            end
            ITER: begin
                add_in1 = shifted;
                add_in2 = ~b_q;
                add_cin = 1'b1;
            end
            NEGQ: begin
                add_in1 = ~q_q;
                add_cin = 1'b1;
            end
            NEGR: begin
                add_in1 = ~r_q;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt_q      <= '0;
            rem_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            rsp_data_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q      <= req_a;
                        b_q      <= req_b;
                        rem_q    <= req_rem;
                        sign_a_q <= req_signed & req_a[XLEN-1];
                        sign_b_q <= req_signed & req_b[XLEN-1];
                        if (b_zero) begin
                            rsp_data_q <= req_rem ? req_a : '1;
                            state_q    <= DONE;
                        end else if (ovf) begin
                            rsp_data_q <= req_rem ? '0 : req_a;
                            state_q    <= DONE;
                        end else begin
                            state_q <= NEGA;
                        end
                    end
                end
                NEGA: begin
                    if (sign_a_q) a_q <= add_out;
                    state_q <= NEGB;
                end
                NEGB: begin
                    if (sign_b_q) b_q <= add_out;
                    r_q     <= '0;
                    q_q     <= a_q;
                    cnt_q   <= '0;
                    state_q <= ITER;
                end
                ITER: begin
                    r_q   <= ok ? add_out : shifted;
                    q_q   <= {q_q[XLEN-2:0], ok};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == '1) state_q <= NEGQ;
                end
                NEGQ: begin
                    if (sign_a_q ^ sign_b_q) q_q <= add_out;
                    state_q <= NEGR;
                end
                NEGR: begin
                    if (sign_a_q) r_q <= add_out;
                    // Remainder takes the dividend's sign.
                    if (rem_q) begin
                        rsp_data_q <= sign_a_q ? add_out : r_q;
                    end else begin
                        rsp_data_q <= q_q;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050518_div_seq.sv
// Self-checking bench for ysyx_22050518_div_seq.
// Models the external adder and checks results against plain arithmetic.
module tb_ysyx_22050518_div_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_signed = 1'b0;
    logic        req_rem = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic [63:0] add_in1;
    logic [63:0] add_in2;
    logic        add_cin;
    logic [63:0] add_out;
    logic        add_cout;

    int tests = 0;
    int fails = 0;

    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    assign {add_cout, add_out} = {1'b0, add_in1} + {1'b0, add_in2}
                               + {64'd0, add_cin};

    ysyx_22050518_div_seq dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_signed(req_signed), .req_rem(req_rem),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .add_in1(add_in1), .add_in2(add_in2), .add_cin(add_cin),
        .add_out(add_out), .add_cout(add_cout)
    );

    function automatic logic [63:0] ref_div(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic s,
                                            input logic r);
        logic [63:0] q;
        logic [63:0] m;
        if (b == 64'd0) begin
            q = '1;
            m = a;
        end else if (s && a == MINV && b == '1) begin
            q = a;
            m = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            m = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            m = a % b;
        end
        return r ? m : q;
    endfunction

    function automatic int ref_lat(input logic [63:0] a,
                                   input logic [63:0] b,
                                   input logic s);
        if (b == 64'd0 || (s && a == MINV && b == '1)) return 1;
        return 69;
    endfunction

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic r);
        @(negedge clk);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_signed = s;
        req_rem    = r;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [63:0] d, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 200);
        d = rsp_data;
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 64'd0) begin
            fails++;
            $display("FAIL reset_ctl: ready=%b valid=%b data=%h want 1 0 0",
                     req_ready, rsp_valid, rsp_data);
        end
        tests++;
        if (add_in1 !== 64'd0 || add_in2 !== 64'd0 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL reset_add: in1=%h in2=%h cin=%b want zeros",
                     add_in1, add_in2, add_cin);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [63:0] ta [14] = '{
            64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C,
            64'd100, 64'd100, 64'h1234, 64'h1234, 64'h1234, 64'h1234,
            MINV, MINV, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        logic [63:0] tb_ [14] = '{
            64'd7, 64'd7, 64'd7, 64'd7,
            64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
            64'd0, 64'd0, 64'd0, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001};
        logic ts [14] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
        logic tr [14] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        logic [63:0] te [14] = '{
            64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE,
            64'hFFFF_FFFF_FFFF_FFF2, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234,
            MINV, 64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFE};
        int tl [14] = '{69, 69, 69, 69, 69, 69, 1, 1, 1, 1, 1, 1, 69, 69};
        logic [63:0] d;
        int lat;
        for (int i = 0; i < 14; i++) begin
            send(ta[i], tb_[i], ts[i], tr[i]);
            wait_rsp(d, lat);
            tests++;
            if (d !== te[i] || lat != tl[i]) begin
                fails++;
                $display("FAIL directed[%0d]: data=%h lat=%0d want %h %0d",
                         i, d, lat, te[i], tl[i]);
            end
            take();
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic s;
        logic r;
        logic [63:0] d;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = 1'($urandom);
            r = 1'($urandom);
            case ($urandom_range(0, 4))
                1: begin
                    a = 64'($urandom_range(0, 1000));
                    b = 64'($urandom_range(1, 50));
                end
                2: b = 64'd0;
                3: begin
                    a = MINV;
                    b = '1;
                end
                4: b = $urandom_range(0, 1) ? 64'($urandom_range(1, 99))
                                            : -64'($urandom_range(1, 99));
                default: ;
            endcase
            send(a, b, s, r);
            wait_rsp(d, lat);
            tests++;
            if (d !== ref_div(a, b, s, r) || lat != ref_lat(a, b, s)) begin
                fails++;
                $display("FAIL random[%0d] a=%h b=%h s=%b r=%b: data=%h lat=%0d want %h %0d",
                         i, a, b, s, r, d, lat, ref_div(a, b, s, r),
                         ref_lat(a, b, s));
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a = {$urandom, $urandom};
        logic [63:0] b = 64'($urandom_range(3, 1 << 20));
        logic [63:0] exp_d = ref_div(a, b, 1'b1, 1'b1);
        logic [63:0] d;
        int lat;
        int bad = 0;
        send(a, b, 1'b1, 1'b1);
        wait_rsp(d, lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d) bad++;
            if (add_in1 !== 64'd0 || add_in2 !== 64'd0 || add_cin !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure: %0d unstable samples, data=%h want %h",
                     bad, rsp_data, exp_d);
        end
        take();
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== exp_d) begin
            fails++;
            $display("FAIL after_take: valid=%b data=%h want 0 %h",
                     rsp_valid, rsp_data, exp_d);
        end
    endtask

    task automatic test_flush();
        logic [63:0] d;
        int lat;
        int seen = 0;
        send(64'd123456789, 64'd1000, 1'b0, 1'b0);
        repeat (33) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_iter: valid=%b ready=%b want 0 1",
                     rsp_valid, req_ready);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_no_rsp: valid seen %0d cycles want 0", seen);
        end
        send(64'd1000, 64'd9, 1'b0, 1'b1);
        wait_rsp(d, lat);
        tests++;
        if (d !== 64'd1 || lat != 69) begin
            fails++;
            $display("FAIL flush_next: data=%h lat=%0d want 1 69", d, lat);
        end
        take();
        @(negedge clk);
        flush      = 1'b1;
        req_valid  = 1'b1;
        req_a      = 64'd50;
        req_b      = 64'd5;
        req_signed = 1'b0;
        req_rem    = 1'b0;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        seen      = 0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle: ready=%b want 1", req_ready);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL flush_idle_rsp: valid seen %0d cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] d;
        int lat;
        send(64'd77, 64'd0, 1'b0, 1'b0);
        wait_rsp(d, lat);
        rsp_ready  = 1'b1;
        req_valid  = 1'b1;
        req_a      = 64'hFFFF_FFFF_FFFF_FC18;
        req_b      = 64'd10;
        req_signed = 1'b1;
        req_rem    = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b0 || d !== '1 || lat != 1) begin
            fails++;
            $display("FAIL b2b_done: ready=%b data=%h lat=%0d want 0 ffffffffffffffff 1",
                     req_ready, d, lat);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle: ready=%b valid=%b want 1 0",
                     req_ready, rsp_valid);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_rsp(d, lat);
        tests++;
        if (d !== 64'hFFFF_FFFF_FFFF_FF9C || lat != 69) begin
            fails++;
            $display("FAIL b2b_second: data=%h lat=%0d want ffffffffffffff9c 69",
                     d, lat);
        end
        take();
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        int lat;
        send(64'd999, 64'd3, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 64'd0) begin
            fails++;
            $display("FAIL rst_mid_ctl: ready=%b valid=%b data=%h want 1 0 0",
                     req_ready, rsp_valid, rsp_data);
        end
        tests++;
        if (add_in1 !== 64'd0 || add_in2 !== 64'd0 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_add: in1=%h in2=%h cin=%b want zeros",
                     add_in1, add_in2, add_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(64'd999, 64'd4, 1'b0, 1'b1);
        wait_rsp(d, lat);
        tests++;
        if (d !== 64'd3 || lat != 69) begin
            fails++;
            $display("FAIL rst_mid_next: data=%h lat=%0d want 3 69", d, lat);
        end
        take();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
